// File: rtl/fa_using_ha.sv
// Ripple-carry adder built from half-adder pairs, with an optional
// registered copy of the result qualified by in_vld.

module half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = x_i ^ y_i;
  assign carry_o = x_i & y_i;

endmodule

module fa_using_ha #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic [WIDTH-1:0] s_r,
  output logic             c_r,
  output logic             out_vld
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out
  logic [WIDTH:0] carry;

  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             vld_q, vld_d;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ha1_sum;
    logic ha1_carry;
    logic ha2_sum;
    logic ha2_carry;

    half_adder u_ha1 (
      .x_i    (a[i]),
      .y_i    (b[i]),
      .sum_o  (ha1_sum),
      .carry_o(ha1_carry)
    );

    half_adder u_ha2 (
      .x_i    (ha1_sum),
      .y_i    (carry[i]),
      .sum_o  (ha2_sum),
      .carry_o(ha2_carry)
    );

    // both half-adder carries can never be 1 together, so OR completes the full adder
    assign s[i]       = ha2_sum;
    assign carry[i+1] = ha1_carry | ha2_carry;
  end

  assign c = carry[WIDTH];

  // capture the combinational result only on qualified cycles; valid tracks in_vld
  always_comb begin
    s_d   = s_q;
    c_d   = c_q;
    vld_d = in_vld;
    if (in_vld) begin
      s_d = s;
      c_d = c;
    end
  end

  // result registers; reset clears any in-flight result immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      c_q   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

  assign s_r     = s_q;
  assign c_r     = c_q;
  assign out_vld = vld_q;

endmodule

// File: tb/tb_fa_using_ha.sv
module tb_fa_using_ha;

  logic clk;
  logic rst_n;

  // WIDTH=1 instance
  logic       a1, b1, ci1, s1, c1, v1, sr1, cr1, ov1;
  // WIDTH=4 instance
  logic [3:0] a4, b4, s4, sr4;
  logic       ci4, c4, v4, cr4, ov4;
  // WIDTH=8 instance
  logic [7:0] a8, b8, s8, sr8;
  logic       ci8, c8, v8, cr8, ov8;

  int errors;
  int checks;

  fa_using_ha #(.WIDTH(1)) u_w1 (
    .a(a1), .b(b1), .c_in(ci1), .s(s1), .c(c1), .clk(clk), .rst_n(rst_n),
    .in_vld(v1), .s_r(sr1), .c_r(cr1), .out_vld(ov1)
  );

  fa_using_ha #(.WIDTH(4)) u_w4 (
    .a(a4), .b(b4), .c_in(ci4), .s(s4), .c(c4), .clk(clk), .rst_n(rst_n),
    .in_vld(v4), .s_r(sr4), .c_r(cr4), .out_vld(ov4)
  );

  fa_using_ha #(.WIDTH(8)) u_w8 (
    .a(a8), .b(b8), .c_in(ci8), .s(s8), .c(c8), .clk(clk), .rst_n(rst_n),
    .in_vld(v8), .s_r(sr8), .c_r(cr8), .out_vld(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0; ci1 = 1'b1; v1 = 1'b1;
    a4 = 4'd9; b4 = 4'd8; ci4 = 1'b0; v4 = 1'b1;
    a8 = 8'd200; b8 = 8'd100; ci8 = 1'b1; v8 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cr1, sr1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_w1: got c_r/s_r/out_vld=%b%b%b want 000", cr1, sr1, ov1);
    end
    checks++;
    if ({cr4, sr4, ov4} !== 6'b0) begin
      errors++;
      $display("FAIL reset_w4: got c_r=%b s_r=%h out_vld=%b want 0", cr4, sr4, ov4);
    end
    checks++;
    if ({cr8, sr8, ov8} !== 10'b0) begin
      errors++;
      $display("FAIL reset_w8: got c_r=%b s_r=%h out_vld=%b want 0", cr8, sr8, ov8);
    end
    // combinational path still live during reset: 9+8 = 17, 200+100+1 = 301
    checks++;
    if ({c4, s4} !== 5'd17) begin
      errors++;
      $display("FAIL reset_comb_w4: got %0d want 17", {c4, s4});
    end
    checks++;
    if ({c8, s8} !== 9'd301) begin
      errors++;
      $display("FAIL reset_comb_w8: got %0d want 301", {c8, s8});
    end
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_truth_table_w1();
    logic [1:0] want [8];
    want = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      {a1, b1, ci1} = 3'(i);
      #5;
      checks++;
      if ({c1, s1} !== want[i]) begin
        errors++;
        $display("FAIL truth_w1[%0d]: got %b want %b", i, {c1, s1}, want[i]);
      end
    end
  endtask

  task automatic test_registered_w1();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; v1 = 1'b1;
    #1;
    checks++;
    if ({c1, s1} !== 2'b11) begin
      errors++;
      $display("FAIL reg_w1_comb: got %b want 11", {c1, s1});
    end
    @(negedge clk);
    v1 = 1'b0;
    checks++;
    if ({cr1, sr1, ov1} !== 3'b111) begin
      errors++;
      $display("FAIL reg_w1: got c_r/s_r/out_vld=%b%b%b want 111", cr1, sr1, ov1);
    end
  endtask

  task automatic test_boundary_w8();
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic       cv [3];
    logic [8:0] want;
    av = '{8'hFF, 8'hFF, 8'h00};
    bv = '{8'h01, 8'hFF, 8'h00};
    cv = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      a8 = av[i]; b8 = bv[i]; ci8 = cv[i];
      #1;
      want = 9'(av[i]) + 9'(bv[i]) + 9'(cv[i]);
      checks++;
      if ({c8, s8} !== want) begin
        errors++;
        $display("FAIL boundary_w8[%0d]: got c=%b s=%h want c=%b s=%h",
                 i, c8, s8, want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_pulse_w4();
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd4; ci4 = 1'b0; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    a4 = 4'd1; b4 = 4'd1;
    checks++;
    if (ov4 !== 1'b1 || sr4 !== 4'd7 || cr4 !== 1'b0) begin
      errors++;
      $display("FAIL pulse_w4_cap: got s_r=%0d c_r=%b out_vld=%b want 7 0 1", sr4, cr4, ov4);
    end
    @(negedge clk);
    checks++;
    if (ov4 !== 1'b0 || sr4 !== 4'd7) begin
      errors++;
      $display("FAIL pulse_w4_hold: got s_r=%0d out_vld=%b want 7 0", sr4, ov4);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; ci4 = 1'b1; v4 = 1'b1;
    @(negedge clk);
    checks++;
    if (ov4 !== 1'b1 || sr4 !== 4'd15 || cr4 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_w4_cap: got s_r=%0d c_r=%b out_vld=%b want 15 1 1", sr4, cr4, ov4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov4 !== 1'b0 || sr4 !== 4'd0 || cr4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_w4: got s_r=%0d c_r=%b out_vld=%b want 0 0 0", sr4, cr4, ov4);
    end
    checks++;
    if ({c4, s4} !== 5'd31) begin
      errors++;
      $display("FAIL mid_reset_comb_w4: got %0d want 31", {c4, s4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 1'b0;
    @(negedge clk);
    checks++;
    if (ov4 !== 1'b0 || sr4 !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_idle_w4: got s_r=%0d out_vld=%b want 0 0", sr4, ov4);
    end
    a4 = 4'd5; b4 = 4'd6; ci4 = 1'b1; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    checks++;
    if (ov4 !== 1'b1 || sr4 !== 4'd12 || cr4 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_cap_w4: got s_r=%0d c_r=%b out_vld=%b want 12 0 1", sr4, cr4, ov4);
    end
  endtask

  task automatic test_random_w4();
    int   exp_sum;
    int   sum;
    logic exp_vld;
    int   n_bad;
    n_bad = 0;
    // prime the model with a known capture of 0+0+0
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd0; ci4 = 1'b0; v4 = 1'b1;
    exp_sum = 0;
    exp_vld = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      checks++;
      if (ov4 !== exp_vld || {cr4, sr4} !== 5'(exp_sum)) begin
        errors++;
        n_bad++;
        if (n_bad <= 10)
          $display("FAIL random_w4_reg[%0d]: got c_r,s_r=%0d out_vld=%b want %0d %b",
                   i, {cr4, sr4}, ov4, exp_sum, exp_vld);
      end
      a4  = 4'($urandom_range(0, 15));
      b4  = 4'($urandom_range(0, 15));
      ci4 = 1'($urandom_range(0, 1));
      v4  = 1'($urandom_range(0, 1));
      sum = int'(a4) + int'(b4) + int'(ci4);
      #1;
      checks++;
      if ({c4, s4} !== 5'(sum)) begin
        errors++;
        n_bad++;
        if (n_bad <= 10)
          $display("FAIL random_w4_comb[%0d]: got %0d want %0d", i, {c4, s4}, sum);
      end
      exp_vld = v4;
      if (v4) exp_sum = sum;
    end
    @(negedge clk);
    v4 = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_truth_table_w1();
    test_registered_w1();
    test_boundary_w8();
    test_pulse_w4();
    test_mid_reset();
    test_random_w4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fa_using_ha.md
FA_USING_HA -- requirements
Module: fa_using_ha

Interface
REQ-001 Parameter: WIDTH, default 1, operand bit width (legal range 1..32).
REQ-002 Port: clk  input  1  rising-edge clock for the registered result path.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low, synchronous deassert by the system.
REQ-004 Port: a  input  WIDTH  addend A.
REQ-005 Port: b  input  WIDTH  addend B.
REQ-006 Port: c_in  input  1  carry-in to bit 0.
REQ-007 Port: s  output  WIDTH  combinational sum.
REQ-008 Port: c  output  1  combinational carry-out of the MSB.
REQ-009 Port: in_vld  input  1  qualifies a, b, c_in for capture into the registered path.
REQ-010 Port: s_r  output  WIDTH  registered sum.
REQ-011 Port: c_r  output  1  registered carry-out.
REQ-012 Port: out_vld  output  1  s_r/c_r hold a result captured on the previous clk edge.
REQ-013 Port declaration order SHALL be a, b, c_in, s, c, clk, rst_n, in_vld, s_r, c_r, out_vld, so that a positional 5-port hookup with the default WIDTH is legal.

Function
REQ-014 A separate half_adder submodule SHALL compute sum = x XOR y and carry = x AND y.
REQ-015 Each bit i SHALL be a full adder built from exactly two half_adder instances plus one OR gate: HA1(a[i],b[i]); HA2(HA1.sum, cin_i); s[i] = HA2.sum; cout_i = HA1.carry OR HA2.carry.
REQ-016 cin_0 SHALL be c_in, cin_i SHALL be cout_(i-1), and c SHALL be cout_(WIDTH-1).
REQ-017 {c, s} SHALL equal a + b + c_in, computed modulo 2^(WIDTH+1) without any loss.
REQ-018 s and c SHALL be purely combinational, with zero-cycle latency and no dependence on clk, rst_n or in_vld.
REQ-019 On each rising clk edge with in_vld=1, s_r and c_r SHALL load the current s and c, and out_vld SHALL be set to 1.
REQ-020 On each rising clk edge with in_vld=0, s_r and c_r SHALL hold their values, and out_vld SHALL be cleared to 0.
REQ-021 The registered path SHALL have a latency of exactly 1 cycle and a throughput of one result per cycle with back-to-back in_vld.
REQ-022 Carry overflow SHALL wrap: all-ones + all-ones + 1 gives s = all-ones and c = 1.
REQ-023 X/Z on the inputs is not a supported use, and no X-masking SHALL be done.

Reset
REQ-024 rst_n=0 SHALL immediately force s_r=0, c_r=0 and out_vld=0, regardless of clk.
REQ-025 During reset, s and c SHALL still follow the inputs combinationally.
REQ-026 Reset asserted mid-stream SHALL discard any in-flight result, and the first capture after deassertion occurs on the first rising edge with in_vld=1.

Verification
REQ-027 With WIDTH=1, apply all 8 combinations of (a,b,c_in) in 5-time-unit steps -> {c,s} SHALL be 00,01,01,10,01,10,10,11 in the order 000..111.
REQ-028 With WIDTH=1, a=1, b=1, c_in=1, in_vld=1, clocked once -> s_r=1, c_r=1, out_vld=1 one cycle later, with s=1 and c=1 immediately.
REQ-029 With WIDTH=8, a=8'hFF, b=8'h01, c_in=0 -> s=8'h00, c=1; and a=8'hFF, b=8'hFF, c_in=1 -> s=8'hFF, c=1.
REQ-030 With in_vld pulsed for one cycle with a=3, b=4, c_in=0 (WIDTH=4), then in_vld=0 -> s_r=7 and out_vld=1 for one cycle, then out_vld=0 with s_r holding 7.
REQ-031 Assert rst_n=0 between clock edges while out_vld=1 -> s_r, c_r and out_vld SHALL be 0 before the next edge, while s and c are unaffected.
REQ-032 For WIDTH=4, run 1000 random vectors with in_vld random -> {c,s} SHALL match a+b+c_in every time, and s_r/c_r SHALL match the prior-cycle value whenever out_vld=1.
